// File: rtl/counter_mod6_if.sv
// rtl/counter_mod6_if.sv - load/enable/count signal bundle for the tens-of-seconds digit
//
// Purpose: groups the counter's control inputs and digit outputs.
// Signals:
//   loadn   synchronous active-low parallel load request
//   enable  decrement request from the seconds-ones stage
//   data    4-bit value to load; values above 5 are clamped to 5
//   ones    current digit, 0..5
//   tc      borrow to the minutes stage: enable AND (ones == 0)
//   zero    ones == 0
// Modports: master drives the controls and observes the digit; slave is the counter.
interface counter_mod6_if;
  logic       loadn;
  logic       enable;
  logic [3:0] data;
  logic [3:0] ones;
  logic       tc;
  logic       zero;

  modport master (
    output loadn, enable, data,
    input  ones, tc, zero
  );

  modport slave (
    input  loadn, enable, data,
    output ones, tc, zero
  );
endinterface

// File: rtl/counter_mod6.sv
// rtl/counter_mod6.sv - modulo-6 down-counter with clamped parallel load
//
// Purpose: tens-of-seconds digit of the oven timer. Decrements on each enabled
// edge, wrapping 0 -> 5 and raising tc as the borrow to the minutes stage.
// Ports:
//   clock  system clock, rising edge
//   clrn   asynchronous active-low clear, forces ones to 0
//   bus    counter_mod6_if.slave: loadn, enable, data in; ones, tc, zero out
module counter_mod6 (
  input  logic           clock,
  input  logic           clrn,
  counter_mod6_if.slave  bus
);

  localparam logic [3:0] MAX_DIGIT = 4'd5;

  logic [3:0] ones_q;
  logic [3:0] ones_d;
  logic       is_zero;

  assign is_zero = (ones_q == 4'd0);

  // Load beats enable; out-of-range load values saturate so the register
  // can never leave 0..5.
  always_comb begin
    ones_d = ones_q;
    if (!bus.loadn) begin
      ones_d = (bus.data > MAX_DIGIT) ? MAX_DIGIT : bus.data;
    end else if (bus.enable) begin
      ones_d = is_zero ? MAX_DIGIT : (ones_q - 4'd1);
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      ones_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign bus.ones = ones_q;
  assign bus.zero = is_zero;
  // Borrow is not gated by loadn: it reflects the wrap the count would take.
  assign bus.tc   = bus.enable & is_zero;

endmodule

// File: tb/tb_counter_mod6.sv
// tb/tb_counter_mod6.sv - scoreboard bench for counter_mod6
module tb_counter_mod6;

  logic clock;
  logic clrn;
  int   checks;
  int   failures;
  logic [3:0] model;
  logic [3:0] exp_q[$];

  counter_mod6_if bus ();

  counter_mod6 dut (
    .clock (clock),
    .clrn  (clrn),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check the combinational
  // flags against the model's current state, then check the registered digit
  // popped from the scoreboard after the next rising edge.
  task automatic step(input logic ld, input logic en, input logic [3:0] d, input string tag);
    logic [3:0] nxt;
    logic [3:0] exp;
    @(negedge clock);
    bus.loadn  = ld;
    bus.enable = en;
    bus.data   = d;
    #1;
    check({tag, "_zero"}, {3'd0, bus.zero}, {3'd0, model == 4'd0});
    check({tag, "_tc"},   {3'd0, bus.tc},   {3'd0, en && (model == 4'd0)});
    if (!clrn)         nxt = 4'd0;
    else if (!ld)      nxt = (d > 4'd5) ? 4'd5 : d;
    else if (en)       nxt = (model == 4'd0) ? 4'd5 : model - 4'd1;
    else               nxt = model;
    exp_q.push_back(nxt);
    model = nxt;
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 4'd1, 4'd0);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_ones"}, bus.ones, exp);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    model      = 4'd0;
    clrn       = 1'b0;
    bus.loadn  = 1'b1;
    bus.enable = 1'b1;
    bus.data   = 4'd0;

    // Reset with clock running
    #2;
    check("rst_ones", bus.ones, 4'd0);
    check("rst_zero", {3'd0, bus.zero}, 4'd1);
    check("rst_tc",   {3'd0, bus.tc},   4'd1);
    step(1'b1, 1'b1, 4'd0, "rst_hold");
    step(1'b1, 1'b0, 4'd0, "rst_hold2");
    clrn = 1'b1;

    // Load sequence with clamp, last load wins
    step(1'b0, 1'b0, 4'd9, "ld9");
    step(1'b0, 1'b0, 4'd3, "ld3");
    step(1'b0, 1'b0, 4'd2, "ld2");

    // Count down with wrap: 1,0,5,4,3,2,1,0,5,4
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'd0, "cnt");

    // Hold at 4
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd0, "hold");

    // Down to 0, then load beats wrap
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd0, "to0");
    step(1'b0, 1'b1, 4'd3, "ld_prio");

    // Clamp boundaries
    step(1'b0, 1'b0, 4'd6,  "ld6");
    step(1'b0, 1'b0, 4'd15, "ld15");
    step(1'b0, 1'b0, 4'd5,  "ld5");
    step(1'b0, 1'b0, 4'd0,  "ld0");

    // Mid-count asynchronous clear
    step(1'b1, 1'b1, 4'd0, "pre_clr1");
    step(1'b1, 1'b1, 4'd0, "pre_clr2");
    #2;
    clrn  = 1'b0;
    model = 4'd0;
    #1;
    check("clr_ones", bus.ones, 4'd0);
    check("clr_zero", {3'd0, bus.zero}, 4'd1);
    check("clr_tc",   {3'd0, bus.tc},   4'd1);
    step(1'b1, 1'b1, 4'd0, "clr_hold1");
    step(1'b1, 1'b1, 4'd0, "clr_hold2");
    clrn = 1'b1;
    step(1'b1, 1'b1, 4'd0, "resume1");
    step(1'b1, 1'b1, 4'd0, "resume2");

    check("sb_drained", exp_q.size() == 0 ? 4'd1 : 4'd0, 4'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
